// File: rtl/fetch_stage.sv
// Instruction-fetch stage: owns the PC, addresses the combinational ROM and
// registers each fetched word for decode behind a valid/ready handshake.
module fetch_stage #(
    parameter int                ADDR_W    = 5,
    parameter int                INST_W    = 16,
    parameter logic [ADDR_W-1:0] RESET_PC  = '0,
    parameter logic [INST_W-1:0] HALT_WORD = 16'hFFFF
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              fetch_en,
    output logic [ADDR_W-1:0] imem_addr,
    input  logic [INST_W-1:0] imem_data,
    input  logic              redirect_valid,
    input  logic [ADDR_W-1:0] redirect_addr,
    output logic [INST_W-1:0] inst,
    output logic [ADDR_W-1:0] inst_pc,
    output logic              inst_valid,
    input  logic              inst_ready,
    output logic              halted
);

    localparam logic [0:0] ST_RUN    = 1'b0;
    localparam logic [0:0] ST_HALTED = 1'b1;

    logic [ADDR_W-1:0] pc;
    logic [0:0]        state;
    logic              load;
    logic              is_halt;

    assign imem_addr = pc;
    assign halted    = (state == ST_HALTED);
    assign is_halt   = (imem_data == HALT_WORD);

    // A new word may enter the output register only when it is empty or
    // being handed to decode in this same cycle.
    assign load = (state == ST_RUN) && fetch_en && (!inst_valid || inst_ready);

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            pc         <= RESET_PC;
            inst       <= '0;
            inst_pc    <= '0;
            inst_valid <= 1'b0;
            state      <= ST_RUN;
        end else if (redirect_valid) begin
            // Redirect flushes the output register even if decode stalls.
            pc         <= redirect_addr;
            inst_valid <= 1'b0;
            state      <= ST_RUN;
        end else if (load) begin
            inst       <= imem_data;
            inst_pc    <= pc;
            inst_valid <= 1'b1;
            if (is_halt) begin
                state <= ST_HALTED;
            end else begin
                pc <= pc + ADDR_W'(1);
            end
        end else if (inst_valid && inst_ready) begin
            inst_valid <= 1'b0;
        end
    end

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: a ROM model plus a scoreboard of the
// words decode is expected to accept, checked on every handshake.
module tb_fetch_stage;

    logic        clk;
    logic        rst_n;
    logic        fetch_en;
    logic [4:0]  imem_addr;
    logic [15:0] imem_data;
    logic        redirect_valid;
    logic [4:0]  redirect_addr;
    logic [15:0] inst;
    logic [4:0]  inst_pc;
    logic        inst_valid;
    logic        inst_ready;
    logic        halted;

    logic [5:0]  halt_at;
    logic [20:0] exp_q[$];
    int          total;
    int          bad;

    fetch_stage dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .fetch_en       (fetch_en),
        .imem_addr      (imem_addr),
        .imem_data      (imem_data),
        .redirect_valid (redirect_valid),
        .redirect_addr  (redirect_addr),
        .inst           (inst),
        .inst_pc        (inst_pc),
        .inst_valid     (inst_valid),
        .inst_ready     (inst_ready),
        .halted         (halted)
    );

    // ROM: A000|addr everywhere except an optional halt word at halt_at.
    assign imem_data = ({1'b0, imem_addr} == halt_at) ? 16'hFFFF : (16'hA000 | 16'(imem_addr));

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        total++;
        if (observed !== expected) begin
            bad++;
            $display("[TB] FAIL %s observed=%0h expected=%0h", tag, observed, expected);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic pushExpected(input logic [4:0] pc);
        exp_q.push_back({pc, 16'hA000 | 16'(pc)});
    endtask

    task automatic applyStimulus(input logic en, input logic rdy, input logic rv, input logic [4:0] ra);
        fetch_en       = en;
        inst_ready     = rdy;
        redirect_valid = rv;
        redirect_addr  = ra;
    endtask

    // Every handshake seen by decode must match the head of the scoreboard.
    always @(negedge clk) begin
        if (rst_n && inst_valid && inst_ready) begin
            if (exp_q.size() == 0) begin
                checkOutput("extra_xfer_pc", 32'(inst_pc), 32'h3F);
            end else begin
                logic [20:0] e;
                e = exp_q.pop_front();
                checkOutput("xfer_inst", 32'(inst), 32'(e[15:0]));
                checkOutput("xfer_pc", 32'(inst_pc), 32'(e[20:16]));
            end
        end
    end

    initial begin
        total   = 0;
        bad     = 0;
        halt_at = 6'h3F;
        rst_n   = 1'b0;
        applyStimulus(1'b1, 1'b1, 1'b0, 5'd0);
        tick();
        tick();
        checkOutput("rst_valid", 32'(inst_valid), 32'd0);
        checkOutput("rst_halted", 32'(halted), 32'd0);
        checkOutput("rst_addr", 32'(imem_addr), 32'd0);
        checkOutput("rst_inst", 32'(inst), 32'd0);
        checkOutput("rst_inst_pc", 32'(inst_pc), 32'd0);

        // Streaming from reset: A000..A004, then stall on A004.
        for (int i = 0; i < 5; i++) pushExpected(5'(i));
        rst_n = 1'b1;
        checkOutput("first_cycle_valid", 32'(inst_valid), 32'd0);
        tick();
        checkOutput("seq0_inst", 32'(inst), 32'hA000);
        checkOutput("seq0_valid", 32'(inst_valid), 32'd1);
        tick();
        checkOutput("seq1_pc", 32'(inst_pc), 32'd1);
        tick();
        tick();
        tick();
        inst_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            checkOutput("stall_inst", 32'(inst), 32'hA004);
            checkOutput("stall_inst_pc", 32'(inst_pc), 32'd4);
            checkOutput("stall_pc", 32'(imem_addr), 32'd5);
            checkOutput("stall_valid", 32'(inst_valid), 32'd1);
            tick();
        end
        inst_ready = 1'b1;
        tick();
        checkOutput("resume_inst", 32'(inst), 32'hA005);
        checkOutput("resume_pc", 32'(inst_pc), 32'd5);

        // Redirect while decode is stalled: A005 is flushed, never accepted.
        applyStimulus(1'b1, 1'b0, 1'b1, 5'd12);
        tick();
        checkOutput("redir_flush_valid", 32'(inst_valid), 32'd0);
        checkOutput("redir_addr", 32'(imem_addr), 32'd12);
        applyStimulus(1'b1, 1'b1, 1'b0, 5'd0);
        pushExpected(5'd12);
        tick();
        checkOutput("redir_target_inst", 32'(inst), 32'hA00C);
        checkOutput("redir_target_pc", 32'(inst_pc), 32'd12);

        // Redirect alongside an accepted word: A00C counts, then flush to 30.
        applyStimulus(1'b1, 1'b1, 1'b1, 5'd30);
        tick();
        checkOutput("redir_rdy_valid", 32'(inst_valid), 32'd0);
        checkOutput("redir_rdy_addr", 32'(imem_addr), 32'd30);
        applyStimulus(1'b1, 1'b1, 1'b0, 5'd0);
        pushExpected(5'd30);
        pushExpected(5'd31);
        pushExpected(5'd0);
        pushExpected(5'd1);
        tick();
        checkOutput("wrap_pc30", 32'(inst_pc), 32'd30);
        checkOutput("wrap_addr31", 32'(imem_addr), 32'd31);
        tick();
        checkOutput("wrap_pc31", 32'(inst_pc), 32'd31);
        checkOutput("wrap_addr0", 32'(imem_addr), 32'd0);
        tick();
        checkOutput("wrap_pc0", 32'(inst_pc), 32'd0);
        tick();
        checkOutput("wrap_pc1", 32'(inst_pc), 32'd1);

        // fetch_en low: the last word drains and the PC freezes.
        fetch_en = 1'b0;
        tick();
        checkOutput("noen_valid", 32'(inst_valid), 32'd0);
        checkOutput("noen_addr", 32'(imem_addr), 32'd2);
        tick();
        checkOutput("noen_addr_hold", 32'(imem_addr), 32'd2);

        // Halt word at address 6, reached by redirecting to 4.
        halt_at = 6'd6;
        applyStimulus(1'b1, 1'b1, 1'b1, 5'd4);
        tick();
        applyStimulus(1'b1, 1'b1, 1'b0, 5'd0);
        pushExpected(5'd4);
        pushExpected(5'd5);
        exp_q.push_back({5'd6, 16'hFFFF});
        tick();
        tick();
        tick();
        checkOutput("halt_inst", 32'(inst), 32'hFFFF);
        checkOutput("halt_inst_pc", 32'(inst_pc), 32'd6);
        checkOutput("halt_flag", 32'(halted), 32'd1);
        checkOutput("halt_addr", 32'(imem_addr), 32'd6);
        for (int i = 0; i < 3; i++) begin
            tick();
            checkOutput("halted_no_valid", 32'(inst_valid), 32'd0);
            checkOutput("halted_addr", 32'(imem_addr), 32'd6);
            checkOutput("halted_stays", 32'(halted), 32'd1);
        end
        applyStimulus(1'b1, 1'b1, 1'b1, 5'd0);
        tick();
        checkOutput("unhalt_flag", 32'(halted), 32'd0);
        applyStimulus(1'b1, 1'b1, 1'b0, 5'd0);
        pushExpected(5'd0);
        tick();
        checkOutput("unhalt_inst", 32'(inst), 32'hA000);
        fetch_en = 1'b0;
        tick();

        // Stall at PC 9, then a one-cycle reset mid-stall.
        halt_at = 6'h3F;
        applyStimulus(1'b1, 1'b0, 1'b1, 5'd8);
        tick();
        applyStimulus(1'b1, 1'b0, 1'b0, 5'd0);
        tick();
        tick();
        checkOutput("pre_rst_inst_pc", 32'(inst_pc), 32'd8);
        checkOutput("pre_rst_addr", 32'(imem_addr), 32'd9);
        rst_n = 1'b0;
        tick();
        checkOutput("midrst_valid", 32'(inst_valid), 32'd0);
        checkOutput("midrst_addr", 32'(imem_addr), 32'd0);
        checkOutput("midrst_inst", 32'(inst), 32'd0);
        rst_n      = 1'b1;
        inst_ready = 1'b1;
        pushExpected(5'd0);
        pushExpected(5'd1);
        tick();
        checkOutput("postrst_inst", 32'(inst), 32'hA000);
        tick();
        checkOutput("postrst_inst1", 32'(inst), 32'hA001);
        fetch_en = 1'b0;
        tick();
        checkOutput("final_valid", 32'(inst_valid), 32'd0);
        checkOutput("scoreboard_empty", 32'(exp_q.size()), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
